// File: rtl/pkt_deframer.sv
// Byte-stream packet deframer: PREFIX SRC DST LEN payload CRC8, payload buffered
// and replayed to one of N_DEST channels over a valid/ready stream.
module pkt_deframer #(
  parameter int          N_DEST      = 4,
  parameter int          MAX_LEN     = 16,
  parameter logic [7:0]  PREFIX      = 8'hDD,
  parameter int          CRC_EN      = 1,
  parameter int          TIMEOUT_CYC = 4800
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic [7:0]        m_data_o,
  output logic [N_DEST-1:0] m_valid_o,
  input  logic              m_ready_i,
  output logic              m_last_o,
  output logic [7:0]        m_src_o,
  output logic              pkt_ok_o,
  output logic              crc_err_o,
  output logic              dest_err_o,
  output logic              len_err_o,
  output logic              timeout_o,
  output logic              overrun_o
);
  localparam int PW = $clog2(MAX_LEN) + 1;
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_SRC, S_DST, S_LEN, S_DATA, S_CRC, S_DRAIN} state_e;

  state_e        state_q, state_d;
  logic [7:0]    src_q, src_d, dst_q, dst_d, len_q, len_d, crc_q, crc_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    buf_q [MAX_LEN];
  logic          wr_en, drain, last;
  logic          pkt_ok, crc_err, dest_err, len_err, tmo, ovr;

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] x;
    x = c ^ b;
    for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction

  assign drain = (state_q == S_DRAIN);
  assign last  = drain && (8'(rptr_q) == len_q - 8'd1);

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    crc_d    = crc_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    tcnt_d   = '0;
    wr_en    = 1'b0;
    pkt_ok   = 1'b0;
    crc_err  = 1'b0;
    dest_err = 1'b0;
    len_err  = 1'b0;
    tmo      = 1'b0;
    ovr      = 1'b0;
    case (state_q)
      S_IDLE: if (rx_valid_i && rx_data_i == PREFIX) begin
        state_d = S_SRC;
        wptr_d  = '0;
        rptr_d  = '0;
        crc_d   = '0;
      end
      S_SRC: if (rx_valid_i) begin
        src_d   = rx_data_i;
        crc_d   = crc8(crc_q, rx_data_i);
        state_d = S_DST;
      end
      S_DST: if (rx_valid_i) begin
        dst_d   = rx_data_i;
        crc_d   = crc8(crc_q, rx_data_i);
        state_d = S_LEN;
      end
      S_LEN: if (rx_valid_i) begin
        len_d = rx_data_i;
        crc_d = crc8(crc_q, rx_data_i);
        if (rx_data_i > 8'(MAX_LEN)) begin
          len_err = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = (rx_data_i == 8'd0) ? S_CRC : S_DATA;
        end
      end
      S_DATA: if (rx_valid_i) begin
        wr_en  = 1'b1;
        wptr_d = wptr_q + 1'b1;
        crc_d  = crc8(crc_q, rx_data_i);
        if (8'(wptr_q) == len_q - 8'd1) state_d = S_CRC;
      end
      S_CRC: if (rx_valid_i) begin
        state_d = S_IDLE;
        if (CRC_EN != 0 && rx_data_i != crc_q) crc_err = 1'b1;
        else if (dst_q >= 8'(N_DEST))          dest_err = 1'b1;
        else begin
          pkt_ok = 1'b1;
          if (len_q != 8'd0) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        ovr = rx_valid_i;
        if (m_ready_i) begin
          rptr_d = rptr_q + 1'b1;
          if (last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Inter-byte watchdog only runs while a header/payload is in flight.
    if (state_q inside {S_SRC, S_DST, S_LEN, S_DATA, S_CRC} && !rx_valid_i) begin
      if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
        tmo     = 1'b1;
        state_d = S_IDLE;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
    if (rst_i) begin
      pkt_ok   = 1'b0;
      crc_err  = 1'b0;
      dest_err = 1'b0;
      len_err  = 1'b0;
      tmo      = 1'b0;
      ovr      = 1'b0;
      wr_en    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      crc_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      crc_q   <= crc_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) buf_q[wptr_q[AW-1:0]] <= rx_data_i;
  end

  for (genvar g = 0; g < N_DEST; g++) begin : g_vld
    assign m_valid_o[g] = drain && (dst_q == 8'(g));
  end

  assign m_data_o   = drain ? buf_q[rptr_q[AW-1:0]] : 8'h00;
  assign m_src_o    = drain ? src_q : 8'h00;
  assign m_last_o   = last;
  assign pkt_ok_o   = pkt_ok;
  assign crc_err_o  = crc_err;
  assign dest_err_o = dest_err;
  assign len_err_o  = len_err;
  assign timeout_o  = tmo;
  assign overrun_o  = ovr;
endmodule

// File: tb/tb_pkt_deframer.sv
// Scoreboard bench for pkt_deframer: stimulus pushes expected status pulses and
// output beats into queues; a negedge monitor pops and compares.
module tb_pkt_deframer;
  logic       clk = 1'b0, rst = 1'b1, rx_valid = 1'b0, m_ready = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] m_data, m_src, m_data0, m_src0;
  logic [3:0] m_valid, m_valid0;
  logic       m_last, pkt_ok, crc_err, dest_err, len_err, timeout, overrun;
  logic       m_last0, pkt_ok0, crc_err0, dest_err0, len_err0, timeout0, overrun0;

  int npass = 0, ntot = 0;
  localparam logic [5:0] ST_LEN = 6'b100000, ST_CRC = 6'b010000, ST_DST = 6'b001000,
                         ST_TMO = 6'b000100, ST_OVR = 6'b000010, ST_OK  = 6'b000001;
  logic [5:0]  sq[$];
  logic [20:0] dq[$];

  always #5 clk = ~clk;

  pkt_deframer dut (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready), .m_last_o(m_last),
    .m_src_o(m_src), .pkt_ok_o(pkt_ok), .crc_err_o(crc_err), .dest_err_o(dest_err),
    .len_err_o(len_err), .timeout_o(timeout), .overrun_o(overrun));

  pkt_deframer #(.CRC_EN(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .m_data_o(m_data0), .m_valid_o(m_valid0), .m_ready_i(m_ready), .m_last_o(m_last0),
    .m_src_o(m_src0), .pkt_ok_o(pkt_ok0), .crc_err_o(crc_err0), .dest_err_o(dest_err0),
    .len_err_o(len_err0), .timeout_o(timeout0), .overrun_o(overrun0));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] x;
    x = c ^ b;
    for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction

  // Monitor: status pulses and handshakes checked independently of stimulus.
  logic [20:0] prev_beat;
  logic        stall_q = 1'b0;
  always @(negedge clk) begin
    logic [5:0]  st;
    logic [20:0] beat;
    st   = {len_err, crc_err, dest_err, timeout, overrun, pkt_ok};
    beat = {m_valid, m_data, m_last, m_src};
    if (!rst) begin
      if (st != 6'b0) begin
        if (sq.size() == 0) begin
          ntot++;
          $display("FAIL status_unexpected: got %b expected none", st);
        end else chk("status", 32'(st), 32'(sq.pop_front()));
      end
      if (stall_q) chk("stall_stable", 32'(beat), 32'(prev_beat));
      if (m_valid != 4'b0 && m_ready) begin
        if (dq.size() == 0) begin
          ntot++;
          $display("FAIL beat_unexpected: got %h expected none", beat);
        end else chk("beat", 32'(beat), 32'(dq.pop_front()));
      end
    end
    stall_q   = !rst && m_valid != 4'b0 && !m_ready;
    prev_beat = beat;
  end

  task automatic put(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Sends PREFIX, header, payload and a correct CRC computed from the header and payload.
  task automatic frame(input logic [7:0] s, input logic [7:0] d, input logic [7:0] pl[$]);
    logic [7:0] c;
    c = crc8(crc8(crc8(8'h00, s), d), 8'(pl.size()));
    put(8'hDD); put(s); put(d); put(8'(pl.size()));
    foreach (pl[i]) begin c = crc8(c, pl[i]); put(pl[i]); end
    put(c);
  endtask

  initial begin
    logic [7:0] pl[$];
    // Reset: a PREFIX byte during reset must be ignored.
    idle(2);
    rx_valid = 1'b1; rx_data = 8'hDD;
    @(negedge clk);
    chk("rst_mvalid", 32'(m_valid), 0);
    chk("rst_mdata", 32'(m_data), 0);
    chk("rst_mlast", 32'(m_last), 0);
    chk("rst_msrc", 32'(m_src), 0);
    chk("rst_status", 32'({len_err, crc_err, dest_err, timeout, overrun, pkt_ok}), 0);
    @(posedge clk); #1;
    rst = 1'b0; rx_valid = 1'b0;
    put(8'h01); put(8'h02); put(8'h01); put(8'hAA); put(8'h8A);
    idle(3);

    // Basic frame with leading junk.
    sq.push_back(ST_OK); dq.push_back({4'b0100, 8'hAA, 1'b1, 8'h01});
    put(8'h55); put(8'h3C);
    put(8'hDD); put(8'h01); put(8'h02); put(8'h01); put(8'hAA); put(8'h8A);
    idle(3);

    // Bad CRC: crc_err here, accepted by the CRC_EN=0 instance.
    sq.push_back(ST_CRC);
    put(8'hDD); put(8'h01); put(8'h02); put(8'h01); put(8'hAA);
    rx_valid = 1'b1; rx_data = 8'h8B;
    @(negedge clk);
    chk("nocrc_pkt_ok", 32'(pkt_ok0), 1);
    @(posedge clk); #1; rx_valid = 1'b0;
    @(negedge clk);
    chk("nocrc_mvalid", 32'(m_valid0), 32'h4);
    chk("nocrc_mdata", 32'(m_data0), 32'hAA);
    chk("nocrc_mlast", 32'(m_last0), 1);
    chk("nocrc_msrc", 32'(m_src0), 32'h01);
    idle(3);

    // Zero-length packet, oversize length, bad destination.
    sq.push_back(ST_OK);
    put(8'hDD); put(8'h00); put(8'h00); put(8'h00); put(8'h00);
    idle(2);
    sq.push_back(ST_LEN);
    put(8'hDD); put(8'h00); put(8'h00); put(8'h11);
    idle(2);
    sq.push_back(ST_DST);
    pl = {};
    frame(8'h01, 8'h04, pl);
    idle(2);

    // Back-pressure with m_ready toggling; one overrun byte mid-drain.
    sq.push_back(ST_OK);
    for (int k = 1; k <= 6; k++) dq.push_back({4'b1000, 8'(k), k == 6, 8'h05});
    sq.push_back(ST_OVR);
    pl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    frame(8'h05, 8'h03, pl);
    for (int i = 0; i < 16; i++) begin
      m_ready  = (i % 2 == 1);
      rx_valid = (i == 3);
      rx_data  = 8'h77;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0; m_ready = 1'b1;
    idle(2);
    chk("bp_beats_done", 32'(dq.size()), 0);

    // Timeout after a partial header.
    sq.push_back(ST_TMO);
    put(8'hDD); put(8'h01);
    idle(4700);
    chk("timeout_not_early", 32'(sq.size()), 1);
    for (int i = 0; i < 300 && sq.size() != 0; i++) idle(1);
    chk("timeout_fired", 32'(sq.size()), 0);

    // Reset in the middle of a stalled drain.
    m_ready = 1'b0;
    sq.push_back(ST_OK);
    put(8'hDD); put(8'h01); put(8'h02); put(8'h01); put(8'hAA); put(8'h8A);
    idle(3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    chk("rst_drain_mvalid", 32'(m_valid), 0);
    chk("rst_drain_mdata", 32'(m_data), 0);
    idle(2);

    // Clean frame after the reset.
    sq.push_back(ST_OK);
    dq.push_back({4'b0010, 8'hC3, 1'b0, 8'h07});
    dq.push_back({4'b0010, 8'h5A, 1'b1, 8'h07});
    pl = {8'hC3, 8'h5A};
    frame(8'h07, 8'h01, pl);
    idle(10);

    chk("status_queue_empty", 32'(sq.size()), 0);
    chk("beat_queue_empty", 32'(dq.size()), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
